// File: rtl/wb_timer_pkg.sv
// Shared constants and types for the wb_timer Wishbone timer block.
package wb_timer_pkg;

    localparam int PRESC_W = 16;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_PRESC  = 3'd1;
    localparam logic [2:0] REG_COUNT  = 3'd2;
    localparam logic [2:0] REG_CMP    = 3'd3;
    localparam logic [2:0] REG_STATUS = 3'd4;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_RELOAD = 1;
    localparam int CTRL_IE     = 2;

    typedef struct packed {
        logic ie;
        logic reload;
        logic en;
    } ctrl_t;

    // Replace only the byte lanes enabled in sel.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  sel);
        logic [31:0] r;
        r = old_val;
        for (int i = 0; i < 4; i++)
            if (sel[i]) r[8*i +: 8] = new_val[8*i +: 8];
        return r;
    endfunction

endpackage

// File: rtl/wb_timer_prescaler.sv
// Free-running divider: one-cycle tick every div+1 enabled clocks.
module wb_timer_prescaler
    import wb_timer_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               en,
    input  logic               clr,
    input  logic [PRESC_W-1:0] div,
    output logic               tick
);

    logic [PRESC_W-1:0] presc_cnt;

    // A clear edge restarts the period and never produces a tick itself.
    assign tick = en && !clr && (presc_cnt == div);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            presc_cnt <= '0;
        else if (clr)
            presc_cnt <= '0;
        else if (en)
            presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
    end

endmodule

// File: rtl/wb_timer.sv
// Wishbone classic responder with a prescaled 32-bit compare timer and level irq.
module wb_timer
    import wb_timer_pkg::*;
#(
    parameter int          ADDR_W  = 30,
    parameter logic [31:0] CMP_RST = 32'hFFFF_FFFF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [ADDR_W-1:0] adr_i,
    input  logic [31:0]       dat_i,
    input  logic [3:0]        sel_i,
    input  logic              we_i,
    input  logic              cyc_i,
    input  logic              stb_i,
    output logic              ack_o,
    output logic [31:0]       dat_o,
    output logic              irq_o
);

    ctrl_t              ctrl;
    logic [PRESC_W-1:0] presc;
    logic [31:0]        count;
    logic [31:0]        cmp;
    logic               match;
    logic               tick;
    logic [31:0]        rdata;

    logic [2:0] reg_sel;
    logic       accept;
    logic       wr_ctrl, wr_presc, wr_count, wr_cmp, wr_status;
    logic       hit;
    logic       unused_adr;

    assign reg_sel    = adr_i[2:0];
    assign unused_adr = ^adr_i[ADDR_W-1:3];

    // The ack flop doubles as the IDLE/ACK state: no accept while ack_o is high.
    assign accept    = cyc_i && stb_i && !ack_o;
    assign wr_ctrl   = accept && we_i && (reg_sel == REG_CTRL);
    assign wr_presc  = accept && we_i && (reg_sel == REG_PRESC);
    assign wr_count  = accept && we_i && (reg_sel == REG_COUNT);
    assign wr_cmp    = accept && we_i && (reg_sel == REG_CMP);
    assign wr_status = accept && we_i && (reg_sel == REG_STATUS);

    assign hit   = tick && (count == cmp);
    assign irq_o = match && ctrl.ie;

    wb_timer_prescaler u_prescaler (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en     (ctrl.en),
        .clr    ((wr_ctrl && sel_i[0]) || wr_presc),
        .div    (presc),
        .tick   (tick)
    );

    always_comb begin
        // NOTE: default first so every path assigns rdata and no latch is inferred.
        rdata = '0;
        case (reg_sel)
            REG_CTRL:   rdata = {29'b0, ctrl};
            REG_PRESC:  rdata = {16'b0, presc};
            REG_COUNT:  rdata = count;
            REG_CMP:    rdata = cmp;
            REG_STATUS: rdata = {31'b0, match};
            default:    rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ack_o <= 1'b0;
            dat_o <= '0;
        end else begin
            ack_o <= accept;
            if (accept) dat_o <= rdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctrl  <= '0;
            presc <= '0;
            count <= '0;
            cmp   <= CMP_RST;
            match <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments later in this block override earlier
            // ones, which encodes the priorities: match set beats clear, bus
            // writes to COUNT and CTRL beat the timer's own updates.
            if (wr_status && sel_i[0] && dat_i[0]) match <= 1'b0;

            if (hit) begin
                match <= 1'b1;
                if (ctrl.reload) count   <= '0;
                else             ctrl.en <= 1'b0;
            end else if (tick) begin
                count <= count + 32'd1;
            end

            if (wr_ctrl && sel_i[0])
                ctrl <= ctrl_t'({dat_i[CTRL_IE], dat_i[CTRL_RELOAD], dat_i[CTRL_EN]});
            if (wr_presc)
                presc <= {sel_i[1] ? dat_i[15:8] : presc[15:8],
                          sel_i[0] ? dat_i[7:0]  : presc[7:0]};
            if (wr_count) count <= byte_merge(count, dat_i, sel_i);
            if (wr_cmp)   cmp   <= byte_merge(cmp, dat_i, sel_i);
        end
    end

endmodule
